// File: rtl/rs5_bus_demux.sv
// rtl/rs5_bus_demux.sv - RS5 data-bus demultiplexer with region decode, read pipeline and unmapped-access capture
//
// Decodes addr_i[SEL_HI:SEL_LO] against an ordered table of exclusive upper
// bounds. The result drives a one-hot slave enable. Each read's slave index
// is carried through a RD_LATENCY-deep pipeline so the matching slave's read
// data is routed back to the core. Accesses that hit no region are flagged and
// the first offending address is held.
//
// Ports:
//   clk           clock, all state on rising edge
//   sys_reset_i   synchronous active-high reset
//   en_i          core memory operation enable (one access per cycle)
//   we_i          byte write enables, all-zero means read
//   addr_i        access address
//   data_o        read data to core (zero when rvalid_o is low)
//   rvalid_o      data_o carries a completed read
//   slv_en_o      one-hot slave enable (combinational)
//   slv_data_i    slave read data, slave i at [i*DATA_W +: DATA_W]
//   err_o         one-cycle pulse after an unmapped access is accepted
//   err_sticky_o  sticky unmapped-access flag
//   err_addr_o    address of the first unmapped access since last clear
//   err_clr_i     clears err_sticky_o / err_addr_o
module rs5_bus_demux #(
  parameter int N_SLAVES = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SEL_HI = 31,
  parameter int SEL_LO = 28,
  parameter logic [N_SLAVES*(SEL_HI-SEL_LO+2)-1:0] REGION_LIMIT = {5'h10, 5'h08, 5'h03, 5'h02},
  parameter bit DEFAULT_SLAVE = 1'b1,
  parameter int RD_LATENCY = 1,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                         clk,
  input  logic                         sys_reset_i,
  input  logic                         en_i,
  input  logic [3:0]                   we_i,
  input  logic [ADDR_W-1:0]            addr_i,
  output logic [DATA_W-1:0]            data_o,
  output logic                         rvalid_o,
  output logic [N_SLAVES-1:0]          slv_en_o,
  input  logic [N_SLAVES*DATA_W-1:0]   slv_data_i,
  output logic                         err_o,
  output logic                         err_sticky_o,
  output logic [ADDR_W-1:0]            err_addr_o,
  input  logic                         err_clr_i
);

  localparam int SEL_W = SEL_HI - SEL_LO + 1;
  // Limits are one bit wider than the field so a limit of 2^SEL_W covers the field maximum.
  localparam int LIM_W = SEL_W + 1;
  localparam int IDX_W = $clog2(N_SLAVES);

  logic [LIM_W-1:0] field_ext;
  logic             hit;
  logic [IDX_W-1:0] sel_idx;
  logic             is_read;
  logic             unm_acc;

  assign field_ext = {1'b0, addr_i[SEL_HI:SEL_LO]};

  // Scanning from the top down leaves the lowest matching region selected.
  always_comb begin
    hit     = 1'b0;
    sel_idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (field_ext < REGION_LIMIT[i*LIM_W +: LIM_W]) begin
        hit     = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
    if (DEFAULT_SLAVE && !hit) begin
      hit     = 1'b1;
      sel_idx = IDX_W'(N_SLAVES - 1);
    end
  end

  always_comb begin
    slv_en_o = '0;
    if (en_i && hit && !sys_reset_i) begin
      slv_en_o[sel_idx] = 1'b1;
    end
  end

  assign is_read = en_i && (we_i == 4'b0000);
  assign unm_acc = en_i && !hit;

  // Read pipeline: stage 0 is loaded at accept, the last stage presents the return.
  logic [RD_LATENCY-1:0] st_valid;
  logic [RD_LATENCY-1:0] st_unm;
  logic [IDX_W-1:0]      st_idx [RD_LATENCY];

  always_ff @(posedge clk) begin
    if (sys_reset_i) begin
      st_valid <= '0;
      st_unm   <= '0;
    end else begin
      st_valid[0] <= is_read;
      st_unm[0]   <= !hit;
      st_idx[0]   <= sel_idx;
      for (int k = 1; k < RD_LATENCY; k++) begin
        st_valid[k] <= st_valid[k-1];
        st_unm[k]   <= st_unm[k-1];
        st_idx[k]   <= st_idx[k-1];
      end
    end
  end

  // The slave drives its data in the return cycle, so the mux is combinational.
  always_comb begin
    rvalid_o = st_valid[RD_LATENCY-1];
    data_o   = '0;
    if (st_valid[RD_LATENCY-1]) begin
      if (st_unm[RD_LATENCY-1]) begin
        data_o = ERR_DATA;
      end else begin
        data_o = slv_data_i[int'(st_idx[RD_LATENCY-1])*DATA_W +: DATA_W];
      end
    end
  end

  // A new error outranks a simultaneous clear; while sticky, the first address is kept.
  always_ff @(posedge clk) begin
    if (sys_reset_i) begin
      err_o        <= 1'b0;
      err_sticky_o <= 1'b0;
      err_addr_o   <= '0;
    end else begin
      err_o <= unm_acc;
      if (unm_acc) begin
        err_sticky_o <= 1'b1;
        if (!err_sticky_o || err_clr_i) begin
          err_addr_o <= addr_i;
        end
      end else if (err_clr_i) begin
        err_sticky_o <= 1'b0;
        err_addr_o   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rs5_bus_demux.sv
// tb/tb_rs5_bus_demux.sv - self-checking bench for rs5_bus_demux against a behavioural model
module tb_rs5_bus_demux;

  localparam int MAXC = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         clr = 1'b0;
  logic [3:0]   we = 4'h0;
  logic [31:0]  addr = 32'h0;
  logic [127:0] sd = '0;

  logic [31:0] dat [2];
  logic        rv  [2];
  logic [3:0]  sen [2];
  logic        eo  [2];
  logic        es  [2];
  logic [31:0] ea  [2];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Instance 0: default regions with catch-all last slave, latency 2.
  rs5_bus_demux #(.N_SLAVES(4), .RD_LATENCY(2)) dut_a (
    .clk(clk), .sys_reset_i(rst), .en_i(en), .we_i(we), .addr_i(addr),
    .data_o(dat[0]), .rvalid_o(rv[0]), .slv_en_o(sen[0]), .slv_data_i(sd),
    .err_o(eo[0]), .err_sticky_o(es[0]), .err_addr_o(ea[0]), .err_clr_i(clr)
  );

  // Instance 1: top region ends at 0xC, no catch-all, latency 3.
  rs5_bus_demux #(.N_SLAVES(4), .REGION_LIMIT({5'h0C, 5'h08, 5'h03, 5'h02}),
                  .DEFAULT_SLAVE(1'b0), .RD_LATENCY(3)) dut_b (
    .clk(clk), .sys_reset_i(rst), .en_i(en), .we_i(we), .addr_i(addr),
    .data_o(dat[1]), .rvalid_o(rv[1]), .slv_en_o(sen[1]), .slv_data_i(sd),
    .err_o(eo[1]), .err_sticky_o(es[1]), .err_addr_o(ea[1]), .err_clr_i(clr)
  );

  // Model: per-cycle schedule of expected returns plus error registers.
  int          lat  [2] = '{2, 3};
  bit          dflt [2] = '{1'b1, 1'b0};
  int          lim  [2][4] = '{'{2, 3, 8, 16}, '{2, 3, 8, 12}};
  bit          m_rv  [2][MAXC];
  bit          m_unm [2][MAXC];
  int          m_idx [2][MAXC];
  bit          m_err [2];
  bit          m_stk [2];
  logic [31:0] m_ea  [2];

  function automatic int decode(int s, logic [31:0] a);
    int f;
    f = int'(a[31:28]);
    for (int i = 0; i < 4; i++) begin
      if (f < lim[s][i]) return i;
    end
    return dflt[s] ? 3 : -1;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive, compare every output of both instances, advance the model.
  task automatic step(bit r, bit e, logic [3:0] w, logic [31:0] a, bit c);
    int d;
    logic [3:0] xe;
    logic [31:0] xd;
    bit unm;
    @(posedge clk);
    #1;
    rst = r; en = e; we = w; addr = a; clr = c;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      d = decode(s, a);
      xe = 4'b0000;
      if (!r && e && d >= 0) xe = 4'(1 << d);
      chk($sformatf("slv_en%0d", s), sen[s], xe);
      if (cyc > 0) begin
        xd = 32'h0;
        if (m_rv[s][cyc]) xd = m_unm[s][cyc] ? 32'hDEAD_BEEF : sd[m_idx[s][cyc]*32 +: 32];
        chk($sformatf("rvalid%0d", s), rv[s], m_rv[s][cyc]);
        chk($sformatf("data%0d", s), dat[s], xd);
        chk($sformatf("err%0d", s), eo[s], m_err[s]);
        chk($sformatf("sticky%0d", s), es[s], m_stk[s]);
        chk($sformatf("err_addr%0d", s), ea[s], m_ea[s]);
      end
      if (r) begin
        for (int k = 1; k <= 4; k++) m_rv[s][cyc+k] = 1'b0;
        m_err[s] = 1'b0;
        m_stk[s] = 1'b0;
        m_ea[s]  = 32'h0;
      end else begin
        unm = e && (d < 0);
        if (e && w == 4'h0) begin
          m_rv[s][cyc+lat[s]]  = 1'b1;
          m_unm[s][cyc+lat[s]] = (d < 0);
          m_idx[s][cyc+lat[s]] = (d < 0) ? 0 : d;
        end
        m_err[s] = unm;
        if (unm) begin
          if (!m_stk[s] || c) m_ea[s] = a;
          m_stk[s] = 1'b1;
        end else if (c) begin
          m_stk[s] = 1'b0;
          m_ea[s]  = 32'h0;
        end
      end
    end
    cyc++;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
  endtask

  initial begin
    int pick [8] = '{1, 2, 3, 7, 8, 11, 12, 15};
    logic [31:0] ra;
    logic [3:0] rw;
    sd = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0000};

    // Reset held 3 cycles with en_i high.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'h0, 32'h0, 1'b0);
    chk("rst_slv_en", sen[0], 4'b0000);
    chk("rst_rvalid", rv[0], 1'b0);
    chk("rst_data", dat[0], 32'h0);
    chk("rst_err", {eo[0], es[0], eo[1], es[1]}, 4'b0000);

    // Decode with the default region table.
    step(1'b0, 1'b1, 4'h0, 32'h1FFF_FFFC, 1'b0);
    chk("dec_1fff", sen[0], 4'b0001);
    step(1'b0, 1'b1, 4'h0, 32'h2000_0008, 1'b0);
    chk("dec_2000", sen[0], 4'b0010);
    step(1'b0, 1'b1, 4'h0, 32'h7000_0000, 1'b0);
    chk("dec_7000", sen[0], 4'b0100);
    step(1'b0, 1'b1, 4'hF, 32'h8000_0000, 1'b0);
    chk("dec_8000", sen[0], 4'b1000);
    idle(4);

    // Latency 2: three reads to slaves 0,1,2 return in order.
    sd = {32'h0, 32'hC2, 32'hB1, 32'hA0};
    step(1'b0, 1'b1, 4'h0, 32'h0000_0000, 1'b0);
    step(1'b0, 1'b1, 4'h0, 32'h2000_0000, 1'b0);
    step(1'b0, 1'b1, 4'h0, 32'h4000_0000, 1'b0);
    chk("lat_t2", {rv[0], dat[0]}, {1'b1, 32'hA0});
    idle(1);
    chk("lat_t3", {rv[0], dat[0]}, {1'b1, 32'hB1});
    idle(1);
    chk("lat_t4", {rv[0], dat[0]}, {1'b1, 32'hC2});
    idle(1);
    chk("lat_t5", rv[0], 1'b0);
    idle(3);

    // Unmapped access on the instance without a catch-all.
    step(1'b0, 1'b1, 4'h0, 32'hD000_0004, 1'b0);
    chk("unm_en", sen[1], 4'b0000);
    idle(1);
    chk("unm_flags", {eo[1], es[1], ea[1]}, {1'b1, 1'b1, 32'hD000_0004});
    idle(1);
    chk("unm_pulse_end", eo[1], 1'b0);
    idle(1);
    chk("unm_data", {rv[1], dat[1]}, {1'b1, 32'hDEAD_BEEF});
    step(1'b0, 1'b1, 4'hF, 32'hE000_0000, 1'b0);
    idle(1);
    chk("unm_keep", {eo[1], ea[1]}, {1'b1, 32'hD000_0004});

    // Clear racing a new error, then a lone clear.
    step(1'b0, 1'b1, 4'h0, 32'hF000_0000, 1'b1);
    idle(1);
    chk("race", {es[1], ea[1]}, {1'b1, 32'hF000_0000});
    step(1'b0, 1'b0, 4'h0, 32'h0, 1'b1);
    idle(1);
    chk("clr", {es[1], ea[1]}, {1'b0, 32'h0});
    idle(4);

    // Reset mid-flight on the latency-3 instance.
    step(1'b0, 1'b1, 4'h0, 32'h0000_0000, 1'b0);
    step(1'b1, 1'b0, 4'h0, 32'h0, 1'b0);
    idle(1);
    step(1'b0, 1'b1, 4'h0, 32'h0000_0000, 1'b0);
    chk("mid_t3", rv[1], 1'b0);
    idle(1);
    chk("mid_t4", rv[1], 1'b0);
    idle(1);
    chk("mid_t5", rv[1], 1'b0);
    idle(1);
    chk("mid_t6", {rv[1], dat[1]}, {1'b1, 32'hA0});

    // Randomised traffic with boundary-biased fields.
    for (int i = 0; i < 2000; i++) begin
      sd = {$urandom, $urandom, $urandom, $urandom};
      ra = $urandom;
      if ($urandom_range(1, 0) == 1) ra[31:28] = 4'(pick[$urandom_range(7, 0)]);
      rw = ($urandom_range(1, 0) == 1) ? 4'h0 : 4'($urandom_range(15, 1));
      step($urandom_range(63, 0) == 0, $urandom_range(3, 0) != 0, rw, ra,
           $urandom_range(15, 0) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rs5_bus_demux.md
# rs5_bus_demux

Parametrised data-bus demultiplexer between the RS5 core data port and N memory-mapped slaves (RAM, RTC, PLIC, testbench/IO registers, …). It decodes a configurable address field into ordered regions and drives a one-hot slave enable. It routes slave read data back to the core after a configurable, fully pipelined read latency. It also flags and records accesses to unmapped addresses.

## Interface
Parameters:
- N_SLAVES, 4, number of slave ports (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- SEL_HI / SEL_LO, 31 / 28, decoded address field `addr_i[SEL_HI:SEL_LO]`; SEL_W = SEL_HI-SEL_LO+1
- REGION_LIMIT, {5'h10,5'h08,5'h03,5'h02}, per-slave exclusive upper bound (SEL_W+1 bits each), index 0 = LSB entry; strictly increasing
- DEFAULT_SLAVE, 1, 1: last slave catches every address ≥ REGION_LIMIT[N-2]; 0: addresses ≥ REGION_LIMIT[N-1] are unmapped
- RD_LATENCY, 1, cycles from read accept to data return (1..4)
- ERR_DATA, 32'hDEAD_BEEF, read data returned for unmapped reads

Ports:
- clk  in  1  clock, all state on rising edge
- sys_reset_i  in  1  synchronous, active-high reset
- en_i  in  1  core memory operation enable
- we_i  in  4  byte write enables; all-zero = read
- addr_i  in  ADDR_W  access address
- data_o  out  DATA_W  read data to core
- rvalid_o  out  1  data_o carries a completed read
- slv_en_o  out  N_SLAVES  one-hot slave enable (combinational)
- slv_data_i  in  N_SLAVES*DATA_W  slave read data, slave i at [i*DATA_W +: DATA_W]
- err_o  out  1  one-cycle pulse: unmapped access accepted previous cycle
- err_sticky_o  out  1  sticky unmapped-access flag
- err_addr_o  out  ADDR_W  address of first unmapped access since last clear
- err_clr_i  in  1  clears err_sticky_o / err_addr_o

## Operation
- Decode: f = addr_i[SEL_HI:SEL_LO]. Select the lowest index i with f < REGION_LIMIT[i]. If DEFAULT_SLAVE=1, slave N-1 is selected whenever no lower slave matches.
- No match and DEFAULT_SLAVE=0: access is unmapped.
- slv_en_o[i] = en_i & selected(i) & !sys_reset_i. At most one bit is set. Unmapped accesses give all zeros.
- Every cycle with en_i=1 accepts one access; no stall or backpressure.
- Read pipeline: RD_LATENCY stages, each holding {valid, unmapped, idx}. A stage entry is written only for reads (we_i==0).
- Final stage valid → rvalid_o=1. data_o = ERR_DATA if unmapped, else slv_data_i[idx].
- Final stage invalid → rvalid_o=0, data_o=0.
- Writes produce no pipeline entry and no rvalid_o.
- Unmapped read or write accepted at T:
  - err_o=1 at T+1.
  - If err_sticky_o=0 (or err_clr_i=1 at T), err_addr_o ← addr_i.
  - err_sticky_o ← 1.
- Later errors while sticky do not overwrite err_addr_o.
- err_clr_i alone: err_sticky_o ← 0, err_addr_o ← 0. If an error is accepted in the same cycle, the error wins: sticky=1, address = new address.

## Timing
- Reset values: rvalid_o=0, data_o=0, err_o=0, err_sticky_o=0, err_addr_o=0, all pipeline stages invalid.
- slv_en_o=0 while sys_reset_i=1, regardless of en_i.
- Read accepted at cycle T → rvalid_o and data_o valid during cycle T+RD_LATENCY. The slave must drive slv_data_i in that same cycle.
- Back-to-back reads return on consecutive cycles in issue order. Throughput is 1 per cycle for mixed slaves and mixed reads/writes.
- Reset mid-operation: all in-flight reads are discarded; no rvalid_o is produced for them.
- The first access may be accepted in the cycle after sys_reset_i deasserts.
- Boundary: f == REGION_LIMIT[i]-1 selects slave i; f == REGION_LIMIT[i] selects slave i+1.
- REGION_LIMIT = 2^SEL_W covers up to the field maximum.

## Test plan
- Reset: hold sys_reset_i 3 cycles with en_i=1, addr 0x0 → slv_en_o=0000, rvalid_o=0, data_o=0, err flags 0.
- Decode, defaults:
  - read 0x1FFF_FFFC → slv_en_o=0001
  - read 0x2000_0008 → 0010
  - read 0x7000_0000 → 0100
  - write 0x8000_0000 (we_i=4'hF) → 1000; no rvalid_o
- Latency, RD_LATENCY=2: reads to slaves 0,1,2 at T,T+1,T+2, with slaves returning 0xA0,0xB1,0xC2 at their return cycles → rvalid_o T+2..T+4 with data 0xA0,0xB1,0xC2; rvalid_o=0 at T+5.
- Unmapped, DEFAULT_SLAVE=0, REGION_LIMIT={C,8,3,2}:
  - read 0xD000_0004 at T → slv_en_o=0, err_o=1 at T+1 only, err_sticky_o=1, err_addr_o=0xD000_0004, data_o=0xDEAD_BEEF with rvalid_o at T+RD_LATENCY.
  - Then write 0xE000_0000 → err_o pulses, err_addr_o unchanged.
- Clear race: err_clr_i=1 in the same cycle as an unmapped access to 0xF000_0000 → err_sticky_o=1, err_addr_o=0xF000_0000. A subsequent lone err_clr_i → sticky 0, addr 0.
- Reset mid-flight, RD_LATENCY=3: read at T, sys_reset_i at T+1 → rvalid_o stays 0 through T+5. A read at T+3, after reset deasserts, returns at T+6.
